imul_unit: RTL and testbench

IMUL_UNIT -- requirements
Module: imul_unit

---
 rtl/imul_pkg.sv | 17 +
 rtl/imul_unit.sv | 132 +++++++++++++
 tb/tb_imul_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/imul_pkg.sv
// Shared types for the iterative integer multiplier.
package imul_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULH = 2'b01,
        OP_SMULH = 2'b10,
        OP_UNDEF = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/imul_unit.sv
// Radix-2 shift-add multiplier with a valid/ready request and result handshake.
//
// state  | meaning
// S_IDLE | waiting for a request, in_ready high
// S_BUSY | one shift-add iteration per cycle, N cycles
// S_DONE | result held, out_valid high until out_ready
module imul_unit
    import imul_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero
);

    localparam int CW = $clog2(N + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  prod_q, prod_d;
    logic [N-1:0]    mcand_q, mcand_d;
    op_e             op_q, op_d;
    logic            neg_q, neg_d;
    logic [N-1:0]    result_q, result_d;
    logic            zero_q, zero_d;

    // Iteration datapath: prod holds {accumulator, remaining multiplier bits}.
    logic [N-1:0]    addend;
    logic [N:0]      sum;
    logic [2*N-1:0]  step;
    logic [2*N-1:0]  fin;
    logic [N-1:0]    res_sel;
    logic [N-1:0]    a_mag, b_mag;
    logic            is_smulh;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    // Next-state, operand capture and shift-add iteration.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        zero_d   = zero_q;

        addend   = prod_q[0] ? mcand_q : '0;
        sum      = {1'b0, prod_q[2*N-1:N]} + {1'b0, addend};
        step     = {sum, prod_q[N-1:1]};
        // Sign fix-up happens once on the full 2N-bit product, so the
        // magnitude of the most negative operand never overflows.
        fin      = neg_q ? ('0 - step) : step;
        res_sel  = (op_q == OP_MUL) ? fin[N-1:0] : fin[2*N-1:N];

        is_smulh = (op_e'(op) == OP_SMULH);
        a_mag    = (is_smulh && a[N-1]) ? ('0 - a) : a;
        b_mag    = (is_smulh && b[N-1]) ? ('0 - b) : b;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = op_e'(op);
                    if (op_e'(op) == OP_UNDEF) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        zero_d   = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        mcand_d = a_mag;
                        prod_d  = {{N{1'b0}}, b_mag};
                        neg_d   = is_smulh && (a[N-1] ^ b[N-1]);
                    end
                end
            end
            S_BUSY: begin
                prod_d = step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = S_DONE;
                    prod_d   = fin;
                    result_d = res_sel;
                    zero_d   = (res_sel == '0);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_imul_unit.sv
// Scoreboard bench for imul_unit: directed corner cases plus random requests.
module tb_imul_unit;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a, b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;

    int errors = 0;
    int checks = 0;

    logic [N:0] exp_q[$];   // {zero, result}

    imul_unit #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 128-bit arithmetic on the operands.
    function automatic logic [N:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic [1:0] mop);
        logic [2*N-1:0]        u;
        logic signed [2*N-1:0] s;
        logic [N-1:0]          r;
        u = {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
        s = $signed({{N{ma[N-1]}}, ma}) * $signed({{N{mb[N-1]}}, mb});
        case (mop)
            2'b00:   r = u[N-1:0];
            2'b01:   r = u[2*N-1:N];
            2'b10:   r = s[2*N-1:N];
            default: r = '0;
        endcase
        return {(r == '0), r};
    endfunction

    // Monitor: compares every result handed over on the output handshake.
    always @(negedge clk) begin
        if (!reset) begin
            check("zero_consistent", zero, (result == '0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    logic [N:0] e;
                    e = exp_q.pop_front();
                    check("result", result, e[N-1:0]);
                    check("zero", zero, e[N]);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Issue one request (at #1 after an edge), wait for its result, hold
    // out_ready low for 'hold' DONE cycles, then release it.
    task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic [1:0] top, input int hold);
        int n;
        int exp_edges;
        logic [N-1:0] r0;
        logic         z0;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            do_reset();
            return;
        end
        in_valid = 1'b1; a = ta; b = tb_v; op = top;
        exp_q.push_back(model(ta, tb_v, top));
        @(posedge clk); #1;
        // Undefined op is already DONE after the accept edge; others need N iterations.
        exp_edges = (top == 2'b11) ? 0 : N;
        n = 0;
        while (!out_valid && n < 200) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 2'($urandom);
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("latency_edges", n, exp_edges);
        if (!out_valid) begin
            do_reset();
            return;
        end
        r0 = result; z0 = zero;
        for (int i = 0; i < hold; i++) begin
            a = {$urandom, $urandom}; in_valid = 1'($urandom);
            @(posedge clk); #1;
            check("hold_stable", {out_valid, in_ready, zero, result}, {1'b1, 1'b0, z0, r0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("back_to_idle", {in_ready, out_valid}, 2'b10);
    endtask

    logic [N-1:0] specials [5];

    initial begin
        specials[0] = '0;
        specials[1] = '1;
        specials[2] = {1'b1, {(N-1){1'b0}}};
        specials[3] = {{(N-1){1'b0}}, 1'b1};
        specials[4] = {1'b0, {(N-1){1'b1}}};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_state", {in_ready, out_valid, zero, result}, {1'b1, 1'b0, 1'b1, {N{1'b0}}});

        issue(64'd23, 64'd8, 2'b00, 0);
        issue('1, '1, 2'b00, 0);
        issue('1, '1, 2'b01, 1);
        issue('1, '1, 2'b10, 0);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 0);
        issue('1, 64'd1, 2'b10, 0);
        issue('0, 64'hc0cac01a, 2'b00, 0);
        issue(64'hcaca, 64'd7, 2'b11, 0);
        issue(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 2'b01, 5);

        // Reset during the 30th BUSY cycle discards the operation.
        in_valid = 1'b1; a = 64'd1000; b = 64'd1000; op = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("still_busy", {in_ready, out_valid}, 2'b00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_busy_reset", {in_ready, out_valid, zero, result}, {1'b1, 1'b0, 1'b1, {N{1'b0}}});
        issue(64'd3, 64'd5, 2'b00, 0);

        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : {$urandom, $urandom};
            issue(ra, rb, 2'($urandom), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
